// File: rtl/s1_pkg.sv
// Shared definitions for the S1 pipeline: control-word field positions,
// datapath widths, writeback source select and the bus FSM state encoding.
package s1_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned IP_W   = 30;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CW_W   = 12;

    // Control-word bit positions
    localparam int unsigned CW_MEM_WE       = 7;
    localparam int unsigned CW_MEM_REQ      = 8;
    localparam int unsigned CW_REG_WE       = 9;
    localparam int unsigned CW_REG_INSEL_LO = 10;
    localparam int unsigned CW_REG_INSEL_HI = 11;

    // Writeback data source
    typedef enum logic [1:0] {
        INSEL_ALU       = 2'd0,
        INSEL_UPPER_IMM = 2'd1,
        INSEL_MEM       = 2'd2,
        INSEL_PC4       = 2'd3
    } reg_insel_t;

    // Load/store bus state: BUS_REQ once an access has waited at least one cycle
    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_REQ  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/mem_wb_stage.sv
// Memory + writeback stage of the S1 pipeline.
// Holds one execute-stage result in a stage register, runs the load/store
// bus handshake (stalling upstream while an access is outstanding, with an
// optional timeout), and registers the register-file write port.
// Ports:
//   clk, rst (sync, active-high), clk_en (global advance enable)
//   valid_in, control_word, rd_in, alu_result, store_data, upper_imm, ip_in : from execute
//   stall                                      : upstream must hold its inputs
//   mem_req, mem_we, mem_addr, mem_wdata       : bus request (combinational from stage reg)
//   mem_rdata, mem_ack                         : bus response
//   reg_we, rd_addr, reg_din                   : register-file write port (registered)
//   bus_err                                    : sticky timeout flag
module mem_wb_stage
    import s1_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              valid_in,
    input  logic [CW_W-1:0]   control_word,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   upper_imm,
    input  logic [IP_W-1:0]   ip_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [IP_W-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              reg_we,
    output logic [REG_AW-1:0] rd_addr,
    output logic [XLEN-1:0]   reg_din,
    output logic              bus_err
);

    localparam int unsigned       CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    // Stage register
    logic              s_valid_q;
    logic [CW_W-1:0]   s_cw_q;
    logic [REG_AW-1:0] s_rd_q;
    logic [XLEN-1:0]   s_alu_q;
    logic [XLEN-1:0]   s_sd_q;
    logic [XLEN-1:0]   s_uimm_q;
    logic [IP_W-1:0]   s_ip_q;

    // Bus FSM and timeout counter
    bus_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_cur;

    // Writeback registers
    logic              reg_we_q, reg_we_d;
    logic [REG_AW-1:0] rd_addr_q;
    logic [XLEN-1:0]   reg_din_q, reg_din_d;
    logic              bus_err_q;

    logic              mem_active;
    logic              timeout_hit;
    logic              advance;
    logic [IP_W-1:0]   ip_next;
    reg_insel_t        insel;

    assign mem_active = s_valid_q & s_cw_q[CW_MEM_REQ];
    // Counter is only meaningful once the access has waited; first cycle counts as 0
    assign cnt_cur     = (state_q == BUS_REQ) ? cnt_q : '0;
    assign timeout_hit = (TIMEOUT != 0) && mem_active && !mem_ack && (cnt_cur == CNT_LAST);
    assign stall       = mem_active & ~mem_ack & ~timeout_hit;
    assign advance     = clk_en & ~stall;

    assign mem_req   = mem_active;
    assign mem_we    = mem_active & s_cw_q[CW_MEM_WE];
    assign mem_addr  = s_alu_q[XLEN-1:2];
    assign mem_wdata = s_sd_q;

    assign ip_next = s_ip_q + IP_W'(1);
    assign insel   = reg_insel_t'(s_cw_q[CW_REG_INSEL_HI:CW_REG_INSEL_LO]);

    // Bus FSM next state and wait-cycle counting
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clk_en) begin
            if (stall) begin
                state_d = BUS_REQ;
                if (TIMEOUT != 0) begin
                    cnt_d = cnt_cur + CNT_W'(1);
                end
            end else begin
                state_d = BUS_IDLE;
                cnt_d   = '0;
            end
        end
    end

    // Writeback source select; a timed-out access retires without writing
    always_comb begin
        reg_we_d  = s_valid_q & s_cw_q[CW_REG_WE] & ~timeout_hit;
        reg_din_d = s_alu_q;
        unique case (insel)
            INSEL_ALU:       reg_din_d = s_alu_q;
            INSEL_UPPER_IMM: reg_din_d = s_uimm_q;
            INSEL_MEM:       reg_din_d = s_cw_q[CW_MEM_REQ] ? mem_rdata : '0;
            INSEL_PC4:       reg_din_d = {ip_next, 2'b00};
            default:         reg_din_d = s_alu_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BUS_IDLE;
            cnt_q     <= '0;
            s_valid_q <= 1'b0;
            s_cw_q    <= '0;
            s_rd_q    <= '0;
            s_alu_q   <= '0;
            s_sd_q    <= '0;
            s_uimm_q  <= '0;
            s_ip_q    <= '0;
            reg_we_q  <= 1'b0;
            rd_addr_q <= '0;
            reg_din_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (advance) begin
                s_valid_q <= valid_in & (|control_word);
                s_cw_q    <= control_word;
                s_rd_q    <= rd_in;
                s_alu_q   <= alu_result;
                s_sd_q    <= store_data;
                s_uimm_q  <= upper_imm;
                s_ip_q    <= ip_in;
                reg_we_q  <= reg_we_d;
                rd_addr_q <= s_rd_q;
                reg_din_q <= reg_din_d;
                bus_err_q <= bus_err_q | timeout_hit;
            end
        end
    end

    assign reg_we  = reg_we_q;
    assign rd_addr = rd_addr_q;
    assign reg_din = reg_din_q;
    assign bus_err = bus_err_q;

endmodule
